// File: rtl/tap_responder.sv
// IEEE 1149.1 TAP target that oversamples the JTAG pins on the system clock.
// It implements the 16-state TAP FSM, the instruction register, BYPASS, IDCODE and a boundary register.
module tap_responder #(
    parameter int unsigned         IR_LEN     = 8,
    parameter int unsigned         BSR_LEN    = 16,
    parameter logic [31:0]         IDCODE_VAL = 32'h1BEEF0A5,
    parameter logic [IR_LEN-1:0]   OP_EXTEST  = 8'h00,
    parameter logic [IR_LEN-1:0]   OP_SAMPLE  = 8'h01,
    parameter logic [IR_LEN-1:0]   OP_IDCODE  = 8'hFE,
    parameter logic [IR_LEN-1:0]   OP_BYPASS  = 8'hFF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tck,
    input  logic               tms,
    input  logic               tdi,
    input  logic               trst,
    output logic               tdo,
    output logic               tdo_oe,
    input  logic [BSR_LEN-1:0] capture_in,
    output logic [BSR_LEN-1:0] update_out,
    output logic               extest_active,
    output logic [3:0]         tap_state,
    output logic [IR_LEN-1:0]  ir_out
);

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR = 4'h9,
        PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
    } tap_state_t;

    localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(2'b01);

    logic [1:0]         tck_sync, tms_sync, tdi_sync, trst_sync;
    logic               tck_prev;
    logic               tck_rise, tck_fall, tap_rst, tms_s, tdi_s;
    tap_state_t         state, next_state;
    logic [IR_LEN-1:0]  ir_shift;
    logic [31:0]        idcode_shift;
    logic [BSR_LEN-1:0] bsr_shift;
    logic [BSR_LEN:0]   bsr_cat;
    logic               bypass_reg;
    logic               sel_bsr, sel_idcode, dr_lsb;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tck_sync  <= '0;
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
            tck_prev  <= 1'b0;
        end else begin
            tck_sync  <= {tck_sync[0], tck};
            tms_sync  <= {tms_sync[0], tms};
            tdi_sync  <= {tdi_sync[0], tdi};
            trst_sync <= {trst_sync[0], trst};
            tck_prev  <= tck_sync[1];
        end
    end

    assign tck_rise = tck_sync[1] & ~tck_prev;
    assign tck_fall = ~tck_sync[1] & tck_prev;
    assign tap_rst  = ~trst_sync[1];
    assign tms_s    = tms_sync[1];
    assign tdi_s    = tdi_sync[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        state <= TLR;
        else if (tap_rst)  state <= TLR;
        else if (tck_rise) state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            TLR:      next_state = tms_s ? TLR      : RTI;
            RTI:      next_state = tms_s ? SEL_DR   : RTI;
            SEL_DR:   next_state = tms_s ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = tms_s ? EX1_DR   : SH_DR;
            SH_DR:    next_state = tms_s ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = tms_s ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = tms_s ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = tms_s ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = tms_s ? SEL_DR   : RTI;
            SEL_IR:   next_state = tms_s ? TLR      : CAP_IR;
            CAP_IR:   next_state = tms_s ? EX1_IR   : SH_IR;
            SH_IR:    next_state = tms_s ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = tms_s ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = tms_s ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = tms_s ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = tms_s ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    // OP_BYPASS needs no decode: every unrecognised opcode falls through to bypass.
    assign sel_bsr    = (ir_out == OP_EXTEST) || (ir_out == OP_SAMPLE);
    assign sel_idcode = (ir_out == OP_IDCODE);
    assign dr_lsb     = sel_bsr ? bsr_shift[0] : (sel_idcode ? idcode_shift[0] : bypass_reg);
    assign bsr_cat    = {tdi_s, bsr_shift};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_shift      <= '0;
            idcode_shift  <= '0;
            bsr_shift     <= '0;
            bypass_reg    <= 1'b0;
            ir_out        <= OP_IDCODE;
            update_out    <= '0;
            tdo           <= 1'b1;
            tdo_oe        <= 1'b0;
            extest_active <= 1'b0;
        end else if (tap_rst) begin
            ir_shift      <= '0;
            idcode_shift  <= '0;
            bsr_shift     <= '0;
            bypass_reg    <= 1'b0;
            ir_out        <= OP_IDCODE;
            update_out    <= '0;
            tdo           <= 1'b1;
            tdo_oe        <= 1'b0;
            extest_active <= 1'b0;
        end else begin
            // Rise actions see the pre-transition state; fall actions see the new one.
            if (tck_rise) begin
                case (state)
                    CAP_IR: ir_shift <= IR_CAPTURE;
                    SH_IR:  ir_shift <= {tdi_s, ir_shift[IR_LEN-1:1]};
                    CAP_DR: begin
                        bypass_reg   <= 1'b0;
                        idcode_shift <= IDCODE_VAL;
                        bsr_shift    <= capture_in;
                    end
                    SH_DR: begin
                        if (sel_bsr)         bsr_shift    <= bsr_cat[BSR_LEN:1];
                        else if (sel_idcode) idcode_shift <= {tdi_s, idcode_shift[31:1]};
                        else                 bypass_reg   <= tdi_s;
                    end
                    default: ;
                endcase
            end
            if (tck_fall) begin
                case (state)
                    SH_IR: begin
                        tdo    <= ir_shift[0];
                        tdo_oe <= 1'b1;
                    end
                    SH_DR: begin
                        tdo    <= dr_lsb;
                        tdo_oe <= 1'b1;
                    end
                    default: tdo_oe <= 1'b0;
                endcase
                if (state == UPD_DR && sel_bsr) update_out <= bsr_shift;
            end
            if (state == TLR)                      ir_out <= OP_IDCODE;
            else if (tck_fall && state == UPD_IR)  ir_out <= ir_shift;
            extest_active <= (ir_out == OP_EXTEST);
        end
    end

    assign tap_state = state;

endmodule

// File: tb/tb_tap_responder.sv
// Scoreboard bench for tap_responder: the stimulus queues the expected tdo bits, and a monitor
// pops and compares one bit on every tck rise while tdo_oe is high.
module tb_tap_responder;

    localparam int IR_LEN  = 8;
    localparam int BSR_LEN = 16;

    logic               clk = 1'b0;
    logic               reset, tck, tms, tdi, trst;
    logic               tdo, tdo_oe, extest_active;
    logic [BSR_LEN-1:0] capture_in, update_out;
    logic [3:0]         tap_state;
    logic [IR_LEN-1:0]  ir_out;

    int   errors = 0;
    int   checks = 0;
    logic exp_q[$];
    bit   mon_en = 1'b1;

    always #5 clk = ~clk;

    tap_responder #(
        .IR_LEN    (IR_LEN),
        .BSR_LEN   (BSR_LEN),
        .IDCODE_VAL(32'h1BEEF0A5),
        .OP_EXTEST (8'h00),
        .OP_SAMPLE (8'h01),
        .OP_IDCODE (8'hFE),
        .OP_BYPASS (8'hFF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tck          (tck),
        .tms          (tms),
        .tdi          (tdi),
        .trst         (trst),
        .tdo          (tdo),
        .tdo_oe       (tdo_oe),
        .capture_in   (capture_in),
        .update_out   (update_out),
        .extest_active(extest_active),
        .tap_state    (tap_state),
        .ir_out       (ir_out)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One tck period of 100 ns; every effect of the rise and the fall has settled on return.
    task automatic tick(input logic m, input logic d);
        tms = m;
        tdi = d;
        #20 tck = 1'b1;
        #40 tck = 1'b0;
        #40;
    endtask

    task automatic to_tlr();
        repeat (5) tick(1'b1, 1'b0);
    endtask

    task automatic shift_bits(input logic [63:0] din, input logic [63:0] dexp, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(dexp[i]);
            tick(i == n - 1, din[i]);
        end
    endtask

    task automatic shift_ir(input logic [63:0] din, input logic [63:0] dexp);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(din, dexp, IR_LEN);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic shift_dr(input logic [63:0] din, input logic [63:0] dexp, input int n);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(din, dexp, n);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    task automatic run_tests();
        logic [15:0] cap;
        #25;
        check("rst_state", tap_state, 4'hF);
        check("rst_ir", ir_out, 8'hFE);
        check("rst_update", update_out, 16'h0000);
        check("rst_tdo_oe", tdo_oe, 1'b0);
        check("rst_tdo", tdo, 1'b1);
        check("rst_extest", extest_active, 1'b0);
        reset = 1'b1;
        #20;
        to_tlr();
        check("tlr_state", tap_state, 4'hF);
        check("tlr_ir", ir_out, 8'hFE);
        check("tlr_update", update_out, 16'h0000);
        check("tlr_tdo_oe", tdo_oe, 1'b0);
        tick(1'b0, 1'b0);
        check("rti_state", tap_state, 4'hC);

        shift_dr(64'h0, 64'h1BEEF0A5, 32);
        check("idcode_oe_off", tdo_oe, 1'b0);

        shift_ir(64'hFF, 64'h01);
        check("ir_bypass", ir_out, 8'hFF);
        shift_dr(64'b1101, 64'b1010, 4);

        shift_ir(64'h01, 64'h01);
        check("ir_sample", ir_out, 8'h01);
        check("sample_extest", extest_active, 1'b0);
        capture_in = 16'hA5C3;
        shift_dr(64'h1234, 64'hA5C3, 16);
        check("preload_update", update_out, 16'h1234);

        shift_ir(64'h00, 64'h01);
        check("extest_active", extest_active, 1'b1);
        check("extest_hold", update_out, 16'h1234);
        capture_in = 16'h0F0F;
        shift_dr(64'h8421, 64'h0F0F, 16);
        check("extest_update", update_out, 16'h8421);

        shift_ir(64'h5A, 64'h01);
        check("ir_unknown", ir_out, 8'h5A);
        check("unknown_extest", extest_active, 1'b0);
        shift_dr(64'b011, 64'b110, 3);

        // IR shift split by a pause: capture bits 1,0,0,0 then 0,0,0,0
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        shift_bits(64'b0101, 64'b0001, 4);
        check("ex1ir_state", tap_state, 4'h9);
        tick(1'b0, 1'b0);
        check("pauseir_state", tap_state, 4'hB);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
        check("ex2ir_state", tap_state, 4'h8);
        tick(1'b0, 1'b0);
        check("resume_shir", tap_state, 4'hA);
        shift_bits(64'b1010, 64'b0000, 4);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("ir_paused", ir_out, 8'hA5);

        shift_ir(64'h00, 64'h01);
        capture_in = 16'h3C3C;
        shift_dr(64'h1234, 64'h3C3C, 16);
        check("pre_trst_update", update_out, 16'h1234);
        check("pre_trst_extest", extest_active, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        cap = 16'h3C3C;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(cap[i]);
            tick(1'b0, 1'b1);
        end
        check("mid_shdr", tap_state, 4'h2);

        mon_en = 1'b0;
        trst = 1'b0;
        tck = 1'b1;
        #10 tck = 1'b0;
        #10 tck = 1'b1;
        #15;
        check("trst_state", tap_state, 4'hF);
        check("trst_ir", ir_out, 8'hFE);
        check("trst_update", update_out, 16'h0000);
        check("trst_tdo_oe", tdo_oe, 1'b0);
        check("trst_tdo", tdo, 1'b1);
        check("trst_extest", extest_active, 1'b0);
        tck = 1'b0;
        #5 trst = 1'b1;
        #60;
        mon_en = 1'b1;
        check("post_trst_state", tap_state, 4'hF);

        tick(1'b0, 1'b0);
        check("resume_rti", tap_state, 4'hC);
        shift_dr(64'h0, 64'h1BEEF0A5, 32);
        check("resume_ir", ir_out, 8'hFE);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        reset      = 1'b0;
        trst       = 1'b1;
        tck        = 1'b0;
        tms        = 1'b1;
        tdi        = 1'b0;
        capture_in = '0;
        fork
            begin : monitor
                forever begin
                    logic e;
                    @(posedge tck);
                    if (mon_en && tdo_oe === 1'b1) begin
                        if (exp_q.size() == 0) begin
                            check("tdo_unexpected", {tdo_oe, tdo}, 2'b00);
                        end else begin
                            e = exp_q.pop_front();
                            check("tdo_bit", tdo, e);
                        end
                    end
                end
            end
            run_tests();
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
